seq_detect_param: RTL and testbench

//  Parametrised serial bit-pattern detector (Mealy, registered output) for button/serial inputs.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_sat_counter.sv | 27 ++
 rtl/seq_detect_param.sv | 114 +++++++++++
 tb/tb_seq_detect_param.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and overlap-mode constants for serial pattern detectors
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } seq_state_e;

  localparam int OVL_OFF = 0;
  localparam int OVL_ON  = 1;

endpackage

// File: rtl/seq_sat_counter.sv
// rtl/seq_sat_counter.sv - saturating up-counter with synchronous clear
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_cnt;

  // A clear that coincides with an increment still records that event.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial bit-pattern detector with loadable pattern and match counter
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1010,
  parameter int               OVERLAP  = OVL_OFF,
  parameter int               CNT_W    = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_pat_load,
  input  logic [PAT_W-1:0] i_pat_data,
  input  logic             i_cnt_clr,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_count,
  output logic [PAT_W-1:0] o_pattern,
  output logic             o_busy
);

  localparam int            FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

  seq_state_e       r_state;
  logic [PAT_W-1:0] r_hist;
  logic [PAT_W-1:0] r_pattern;
  logic [FW-1:0]    r_fill;
  logic             r_match;
  logic             r_busy;

  logic             w_accept;
  logic             w_full;
  logic             w_hit;
  logic [PAT_W-1:0] w_shift;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [FW-1:0]    w_fill_nxt;

  assign w_accept = i_enable & i_valid & ~i_pat_load;
  assign w_shift  = {r_hist[PAT_W-2:0], i_bit};
  assign w_full   = (r_state == ST_HUNT) || (r_fill == FILL_FULL);
  assign w_hit    = w_accept && (r_fill >= FILL_LAST) && (w_shift == r_pattern);

  // Pattern load discards history; a non-overlapping match restarts from scratch.
  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (i_pat_load) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (w_hit && (OVERLAP == OVL_OFF)) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (w_accept) begin
      w_hist_nxt = w_shift;
      if (!w_full) begin
        w_fill_nxt = r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= PAT_INIT;
      r_match   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_hit;
      r_busy  <= (w_fill_nxt != '0);
      if (i_pat_load) begin
        r_pattern <= i_pat_data;
      end
      // Disabling parks the FSM without touching history; re-enable picks FILL/HUNT from fill.
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state <= (w_fill_nxt == FILL_FULL) ? ST_HUNT : ST_FILL;
          end
        end
        ST_FILL, ST_HUNT: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= (w_fill_nxt == FILL_FULL) ? ST_HUNT : ST_FILL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  seq_sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_inc    (w_hit),
    .i_clr    (i_cnt_clr),
    .o_count  (o_match_count)
  );

  assign o_match   = r_match;
  assign o_pattern = r_pattern;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed and random checks of seq_detect_param against a bit-list model
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n, en, vld, b, ld, clr;
  logic [3:0] pd;

  logic       m0, m1, m2, y0, y1, y2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [3:0] p0, p1, p2;

  always #5 clk = ~clk;

  seq_detect_param u0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(vld), .i_bit(b),
    .i_pat_load(ld), .i_pat_data(pd), .i_cnt_clr(clr),
    .o_match(m0), .o_match_count(c0), .o_pattern(p0), .o_busy(y0)
  );

  seq_detect_param #(.OVERLAP(1)) u1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(vld), .i_bit(b),
    .i_pat_load(ld), .i_pat_data(pd), .i_cnt_clr(clr),
    .o_match(m1), .o_match_count(c1), .o_pattern(p1), .o_busy(y1)
  );

  seq_detect_param #(.CNT_W(2)) u2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(vld), .i_bit(b),
    .i_pat_load(ld), .i_pat_data(pd), .i_cnt_clr(clr),
    .o_match(m2), .o_match_count(c2), .o_pattern(p2), .o_busy(y2)
  );

  // Model: list of accepted bits since the last clear, per instance (u0, u1 overlapping, u2 2-bit count).
  bit         hq [3][$];
  logic [3:0] mpat [3];
  int         mcnt [3];
  bit         mhit [3];

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hq[k].delete();
      mpat[k] = 4'b1010;
      mcnt[k] = 0;
      mhit[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int         maxc;
      bit         hit;
      logic [3:0] tail;
      maxc = (k == 2) ? 3 : 255;
      hit  = 1'b0;
      if (ld) begin
        mpat[k] = pd;
        hq[k].delete();
      end else if (en && vld) begin
        hq[k].push_back(b);
        if (hq[k].size() >= 4) begin
          for (int i = 0; i < 4; i++) tail[3-i] = hq[k][hq[k].size()-4+i];
          hit = (tail == mpat[k]);
        end
        if (hit && k != 1) hq[k].delete();
        while (hq[k].size() > 4) void'(hq[k].pop_front());
      end
      if (clr) mcnt[k] = hit ? 1 : 0;
      else if (hit && mcnt[k] < maxc) mcnt[k]++;
      mhit[k] = hit;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/match0"}, 32'(m0), 32'(mhit[0]));
    chk({tag, "/match1"}, 32'(m1), 32'(mhit[1]));
    chk({tag, "/match2"}, 32'(m2), 32'(mhit[2]));
    chk({tag, "/count0"}, 32'(c0), 32'(mcnt[0]));
    chk({tag, "/count1"}, 32'(c1), 32'(mcnt[1]));
    chk({tag, "/count2"}, 32'(c2), 32'(mcnt[2]));
    chk({tag, "/busy0"}, 32'(y0), 32'(hq[0].size() != 0));
    chk({tag, "/busy1"}, 32'(y1), 32'(hq[1].size() != 0));
    chk({tag, "/busy2"}, 32'(y2), 32'(hq[2].size() != 0));
    chk({tag, "/pat0"}, 32'(p0), 32'(mpat[0]));
    chk({tag, "/pat1"}, 32'(p1), 32'(mpat[1]));
    chk({tag, "/pat2"}, 32'(p2), 32'(mpat[2]));
  endtask

  task automatic step(input bit e, input bit v, input bit bi, input bit l,
                      input logic [3:0] d, input bit c, input string tag);
    en = e; vld = v; b = bi; ld = l; pd = d; clr = c;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send(input bit bi, input string tag);
    step(1'b1, 1'b1, bi, 1'b0, 4'h0, 1'b0, tag);
  endtask

  task automatic send4(input logic [3:0] bits, input string tag);
    for (int i = 3; i >= 0; i--) send(bits[i], tag);
  endtask

  initial begin
    int exp5 [5];
    exp5 = '{1, 2, 3, 3, 3};
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0; en = 1'b0; vld = 1'b0; b = 1'b0; ld = 1'b0; pd = 4'h0; clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "post_reset");

    send4(4'b1010, "t1");
    chk("t1_pulse", 32'(m0), 32'd1);
    send(1'b1, "t1");
    send(1'b0, "t1");
    chk("t1_count", 32'(c0), 32'd1);
    chk("t2_count", 32'(c1), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "clr");

    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, "t3_load");
    for (int i = 3; i >= 0; i--) begin
      int gap;
      logic [3:0] pb;
      pb = 4'b1101;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'($urandom), 1'b0, 4'h0, 1'b0, "t3_gap");
      send(pb[i], "t3");
    end
    chk("t3_pulse", 32'(m0), 32'd1);
    chk("t3_pattern", 32'(p0), 32'hd);

    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, "t4_load");
    send(1'b1, "t4"); send(1'b0, "t4"); send(1'b1, "t4");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1010, 1'b0, "t4_collide");
    chk("t4_nomatch", 32'(m0), 32'd0);
    chk("t4_busy", 32'(y0), 32'd0);

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "t5_clr");
    for (int i = 0; i < 5; i++) begin
      send4(4'b1010, "t5");
      chk("t5_sat_count", 32'(c2), 32'(exp5[i]));
    end
    send(1'b1, "t5"); send(1'b0, "t5"); send(1'b1, "t5");
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "t5_clr_hit");
    chk("t5_clr_hit_count", 32'(c2), 32'd1);

    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, "t6_load");
    send(1'b1, "t6"); send(1'b0, "t6"); send(1'b1, "t6");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    chk("t6_pattern_init", 32'(p0), 32'ha);
    #2 rst_n = 1'b1;
    send4(4'b1010, "t6_after");
    chk("t6_pulse", 32'(m0), 32'd1);

    send(1'b1, "en"); send(1'b0, "en");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 4'h0, 1'b0, "en_off");
    send(1'b1, "en"); send(1'b0, "en");
    chk("en_resume_pulse", 32'(m0), 32'd1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 39) == 0, 4'($urandom), $urandom_range(0, 49) == 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
